// File: rtl/kof_input_pkg.sv
// Shared definitions for the keyboard input path: action indices, the
// action-to-HID-keycode map and the reserved HID codes.
package kof_input_pkg;

    typedef enum logic [3:0] {
        P1_LEFT      = 4'd0,
        P1_RIGHT     = 4'd1,
        P1_ATTACK    = 4'd2,
        P1_DEFENSE   = 4'd3,
        P2_LEFT      = 4'd4,
        P2_RIGHT     = 4'd5,
        P2_ATTACK    = 4'd6,
        P2_DEFENSE   = 4'd7,
        GAME_START   = 4'd8,
        GAME_RESTART = 4'd9
    } action_t;

    localparam int KEYMAP_LEN = 10;

    localparam logic [7:0] KC_NONE     = 8'h00;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    // Entry 0 is the rightmost element; START and RESTART share the space bar.
    localparam logic [KEYMAP_LEN-1:0][7:0] KEYMAP = {
        8'h2C, 8'h2C, 8'h51, 8'h52, 8'h4F,
        8'h50, 8'h16, 8'h1A, 8'h07, 8'h04
    };

    // Actions beyond the map decode to KC_NONE, which never matches.
    function automatic logic [7:0] keymap_code(input int idx);
        logic [7:0] code;
        if ((idx >= 0) && (idx < KEYMAP_LEN)) begin
            code = KEYMAP[idx[3:0]];
        end else begin
            code = KC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_action_channel.sv
// One action lane: tick-based debounce of the raw match, registered
// press/release edges and auto-repeat pulse generation.
module key_action_channel
    import kof_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic held,
    output logic held_nxt,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RCNT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    localparam logic [CNT_W-1:0]  DB_C    = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [RCNT_W-1:0] DELAY_C = RCNT_W'(REPEAT_DELAY);
    // Reaching DELAY+RATE folds back to DELAY, so the window repeats forever.
    localparam logic [RCNT_W-1:0] WRAP_C  = RCNT_W'(REPEAT_DELAY + REPEAT_RATE);

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc_s;
    logic              held_q, held_d;
    logic              pressed_q, pressed_d;
    logic              released_q, released_d;
    logic              repeat_q, repeat_d;

    assign cnt_inc_s  = cnt_q + CNT_W'(1);
    assign rcnt_inc_s = rcnt_q + RCNT_W'(1);

    // Debounce: a mismatch must survive DEBOUNCE_TICKS ticks before held follows raw.
    always_comb begin
        cnt_d      = cnt_q;
        held_d     = held_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (tick && (raw != held_q)) begin
            if (cnt_inc_s >= DB_C) begin
                held_d     = raw;
                cnt_d      = '0;
                pressed_d  = raw;
                released_d = ~raw;
            end else begin
                cnt_d = cnt_inc_s;
            end
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Auto-repeat: counts ticks while held; press and release both restart it.
    always_comb begin
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        if (!held_d || pressed_d) begin
            rcnt_d = '0;
        end else if (!tick) begin
            rcnt_d = rcnt_q;
        end else if (REPEAT_RATE == 0) begin
            if (rcnt_q < DELAY_C) begin
                rcnt_d = rcnt_inc_s;
            end else begin
                rcnt_d = rcnt_q;
            end
        end else if (rcnt_inc_s == WRAP_C) begin
            rcnt_d   = DELAY_C;
            repeat_d = 1'b1;
        end else begin
            rcnt_d   = rcnt_inc_s;
            repeat_d = (rcnt_inc_s == DELAY_C);
        end
    end

    // Lane state and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rcnt_q     <= '0;
            held_q     <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            held_q     <= held_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            repeat_q   <= repeat_d;
        end
    end

    assign held         = held_q;
    assign held_nxt     = held_d;
    assign pressed      = pressed_q;
    assign released     = released_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: rtl/key_action_decoder.sv
// Keycode-slot to game-action decoder: registers the HID slots, matches them
// against the key map and feeds one debounce/repeat lane per action.
module key_action_decoder
    import kof_input_pkg::*;
#(
    parameter int NUM_SLOTS      = 6,
    parameter int NUM_ACTIONS    = 10,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [8*NUM_SLOTS-1:0] keycodes,
    input  logic                   tick,
    input  logic                   enable,
    output logic [NUM_ACTIONS-1:0] held,
    output logic [NUM_ACTIONS-1:0] pressed,
    output logic [NUM_ACTIONS-1:0] released,
    output logic [NUM_ACTIONS-1:0] repeat_pulse,
    output logic                   any_held
);

    logic [8*NUM_SLOTS-1:0] kc_q, kc_d;
    logic [NUM_ACTIONS-1:0] raw_q, raw_d;
    logic [NUM_ACTIONS-1:0] match_s;
    logic [NUM_ACTIONS-1:0] held_nxt_s;
    logic [NUM_SLOTS-1:0]   roll_hit_s;
    logic                   rollover_s;
    logic                   any_held_q, any_held_d;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_roll
        assign roll_hit_s[s] = (kc_q[8*s +: 8] == KC_ROLLOVER);
    end
    assign rollover_s = |roll_hit_s;

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_match
        localparam logic [7:0] CODE = keymap_code(a);
        logic [NUM_SLOTS-1:0] slot_hit_s;
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            assign slot_hit_s[s] = (CODE != KC_NONE) && (kc_q[8*s +: 8] == CODE);
        end
        assign match_s[a] = |slot_hit_s;
    end

    // Raw match: an ErrorRollOver report carries no key state, so keep the last one.
    always_comb begin
        kc_d       = keycodes;
        any_held_d = |held_nxt_s;
        if (!enable) begin
            raw_d = '0;
        end else if (rollover_s) begin
            raw_d = raw_q;
        end else begin
            raw_d = match_s;
        end
    end

    // Input capture and summary flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q       <= '0;
            raw_q      <= '0;
            any_held_q <= 1'b0;
        end else begin
            kc_q       <= kc_d;
            raw_q      <= raw_d;
            any_held_q <= any_held_d;
        end
    end

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_chan
        key_action_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk          (Clk),
            .rst_n        (Reset_n),
            .tick         (tick),
            .raw          (raw_q[a]),
            .held         (held[a]),
            .held_nxt     (held_nxt_s[a]),
            .pressed      (pressed[a]),
            .released     (released[a]),
            .repeat_pulse (repeat_pulse[a])
        );
    end

    assign any_held = any_held_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Directed bench for key_action_decoder with a tick-level behavioural model
// compared on every cycle, plus literal expectations for each scenario.
module tb_key_action_decoder;

    localparam int NS = 6;
    localparam int NA = 10;
    localparam int DB = 2;
    localparam int RD = 30;
    localparam int RR = 6;

    logic            Clk      = 1'b0;
    logic            Reset_n  = 1'b0;
    logic            tick     = 1'b0;
    logic            enable   = 1'b1;
    logic [8*NS-1:0] keycodes = '0;
    logic [NA-1:0]   held, pressed, released, repeat_pulse;
    logic            any_held;

    key_action_decoder #(
        .NUM_SLOTS      (NS),
        .NUM_ACTIONS    (NA),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .keycodes     (keycodes),
        .tick         (tick),
        .enable       (enable),
        .held         (held),
        .pressed      (pressed),
        .released     (released),
        .repeat_pulse (repeat_pulse),
        .any_held     (any_held)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: debounce as tick counts, repeat as ticks-since-press arithmetic.
    logic [7:0]    map_m [NA] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h50,
                                  8'h4F, 8'h52, 8'h51, 8'h2C, 8'h2C};
    logic [7:0]    kc_m [NS];
    logic [NA-1:0] raw_m, held_m, pr_m, rl_m, rp_m;
    logic          any_m;
    int            cnt_m [NA];
    int            since_m [NA];
    bit            model_ok = 1'b0;

    task automatic model_clear();
        for (int s = 0; s < NS; s++) kc_m[s] = 8'h00;
        for (int a = 0; a < NA; a++) begin
            cnt_m[a]   = 0;
            since_m[a] = 0;
        end
        raw_m = '0; held_m = '0; pr_m = '0; rl_m = '0; rp_m = '0; any_m = 1'b0;
        model_ok = 1'b1;
    endtask

    task automatic model_step();
        bit roll, hit;
        if (!Reset_n) begin
            model_clear();
        end else begin
            for (int a = 0; a < NA; a++) begin
                pr_m[a] = 1'b0; rl_m[a] = 1'b0; rp_m[a] = 1'b0;
                if (tick) begin
                    if (raw_m[a] != held_m[a]) begin
                        cnt_m[a]++;
                        if (cnt_m[a] >= DB) begin
                            held_m[a] = raw_m[a];
                            cnt_m[a]  = 0;
                            if (raw_m[a]) pr_m[a] = 1'b1;
                            else          rl_m[a] = 1'b1;
                        end
                    end else begin
                        cnt_m[a] = 0;
                    end
                end
                if (pr_m[a] || !held_m[a]) begin
                    since_m[a] = 0;
                end else if (tick) begin
                    since_m[a]++;
                    rp_m[a] = (RR > 0) ? ((since_m[a] >= RD) && (((since_m[a] - RD) % RR) == 0)) : 1'b0;
                end
            end
            any_m = |held_m;
            roll = 1'b0;
            for (int s = 0; s < NS; s++) if (kc_m[s] == 8'h01) roll = 1'b1;
            for (int a = 0; a < NA; a++) begin
                hit = 1'b0;
                for (int s = 0; s < NS; s++) if ((map_m[a] != 8'h00) && (kc_m[s] == map_m[a])) hit = 1'b1;
                if (!enable)   raw_m[a] = 1'b0;
                else if (!roll) raw_m[a] = hit;
            end
            for (int s = 0; s < NS; s++) kc_m[s] = keycodes[8*s +: 8];
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        if (model_ok) begin
            check("cmp_held",     32'(held),         32'(held_m));
            check("cmp_pressed",  32'(pressed),      32'(pr_m));
            check("cmp_released", 32'(released),     32'(rl_m));
            check("cmp_repeat",   32'(repeat_pulse), 32'(rp_m));
            check("cmp_any_held", 32'(any_held),     32'(any_m));
        end
    end

    logic tick_now = 1'b0;
    int   phase    = 0;

    // One clock: tick drawn every 4th cycle, model stepped on the edge, sample 1 ns later.
    task automatic cyc();
        @(negedge Clk);
        tick  = (phase == 3);
        phase = (phase + 1) % 4;
        @(posedge Clk);
        tick_now = tick;
        model_step();
        #1;
    endtask

    // Wait for a press/release pulse; ticks counts ticks from the 3rd edge on.
    task automatic wait_pulse(input logic [NA-1:0] mask, input bit rel, input int budget,
                              output int ticks, output bit found);
        int idx;
        ticks = 0; found = 1'b0; idx = 0;
        while (!found && (idx < budget)) begin
            cyc();
            idx++;
            if ((idx >= 3) && tick_now) ticks++;
            if ((((rel ? released : pressed)) & mask) != '0) found = 1'b1;
        end
    endtask

    task automatic expect_edge(input string name, input logic [NA-1:0] mask, input bit rel,
                               input int exp_ticks);
        int t; bit f; logic [NA-1:0] v;
        wait_pulse(mask, rel, 200, t, f);
        check({name, "_seen"}, 32'(f), 32'd1);
        v = rel ? released : pressed;
        check({name, "_vec"}, 32'(v), 32'(mask));
        if (exp_ticks >= 0) check({name, "_ticks"}, 32'(t), 32'(exp_ticks));
    endtask

    int            pos [4];
    int            exp_pos [4] = '{30, 36, 42, 48};
    int            tk, np, guard, late;
    logic [NA-1:0] acc;

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_held",     32'(held),         32'd0);
        check("rst_pressed",  32'(pressed),      32'd0);
        check("rst_repeat",   32'(repeat_pulse), 32'd0);
        check("rst_any_held", 32'(any_held),     32'd0);
        Reset_n = 1'b1;
        repeat (4) cyc();

        // 0x1A in slot 3: P1_ATTACK press and release
        keycodes[31:24] = 8'h1A;
        expect_edge("atk_press", 10'b0000000100, 1'b0, 2);
        check("atk_held_only", 32'(held), 32'h004);
        check("atk_any_held", 32'(any_held), 32'd1);
        keycodes = '0;
        expect_edge("atk_rel", 10'b0000000100, 1'b1, 2);
        check("atk_held_clr", 32'(held), 32'd0);

        // Glitch: 0x04 seen by exactly one tick
        acc = '0;
        keycodes[7:0] = 8'h04;
        repeat (4) begin cyc(); acc = acc | pressed | released | repeat_pulse | held; end
        keycodes = '0;
        repeat (40) begin cyc(); acc = acc | pressed | released | repeat_pulse | held; end
        check("glitch_quiet", 32'(acc), 32'd0);

        // Auto-repeat on 0x50 held for 50 ticks
        keycodes[7:0] = 8'h50;
        expect_edge("p2l_press", 10'b0000010000, 1'b0, 2);
        tk = 0; np = 0; guard = 0;
        for (int i = 0; i < 4; i++) pos[i] = 0;
        while ((tk < 50) && (guard < 400)) begin
            cyc();
            guard++;
            if (tick_now) tk++;
            if (repeat_pulse[4]) begin
                if (np < 4) pos[np] = tk;
                np++;
            end
        end
        check("rep_count", 32'(np), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rep_pos%0d", i), 32'(pos[i]), 32'(exp_pos[i]));
        keycodes = '0;
        expect_edge("p2l_rel", 10'b0000010000, 1'b1, 2);
        late = 0;
        repeat (40) begin cyc(); if (repeat_pulse[4]) late++; end
        check("rep_after_rel", 32'(late), 32'd0);

        // Shared code 0x2C, then ErrorRollOver in slot 5
        keycodes[7:0] = 8'h2C;
        expect_edge("start_press", 10'b1100000000, 1'b0, 2);
        keycodes[7:0]   = 8'h00;
        keycodes[47:40] = 8'h01;
        repeat (16) begin cyc(); check("roll_held", 32'(held[9:8]), 32'd3); end
        keycodes = '0;
        expect_edge("start_rel", 10'b1100000000, 1'b1, 2);

        // Async reset with 0x07 held and repeat counting
        keycodes[15:8] = 8'h07;
        expect_edge("p1r_press", 10'b0000000010, 1'b0, 2);
        repeat (40) cyc();
        #1;
        Reset_n = 1'b0;
        #1;
        model_clear();
        check("arst_held",     32'(held),         32'd0);
        check("arst_pressed",  32'(pressed),      32'd0);
        check("arst_released", 32'(released),     32'd0);
        check("arst_repeat",   32'(repeat_pulse), 32'd0);
        check("arst_any_held", 32'(any_held),     32'd0);
        repeat (2) cyc();
        Reset_n = 1'b1;
        expect_edge("p1r_repress", 10'b0000000010, 1'b0, 2);
        keycodes = '0;
        expect_edge("p1r_rel", 10'b0000000010, 1'b1, 2);

        // enable dropped with 0x16 and 0x51 held
        keycodes[7:0]  = 8'h16;
        keycodes[15:8] = 8'h51;
        expect_edge("def_press", 10'b0010001000, 1'b0, 2);
        enable = 1'b0;
        expect_edge("def_rel", 10'b0010001000, 1'b1, -1);
        cyc();
        check("def_any_held", 32'(any_held), 32'd0);
        check("def_held", 32'(held), 32'd0);
        keycodes = '0;
        enable   = 1'b1;
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
